// File: rtl/pipeline_ctrl_gen_pkg.sv
// pipeline_ctrl_gen_pkg: exception codes, vector offsets and controller state encoding
package pipeline_ctrl_gen_pkg;
    localparam logic [31:0] EXC_INTERRUPT    = 32'h1;
    localparam logic [31:0] EXC_SYSCALL      = 32'h8;
    localparam logic [31:0] EXC_INVALID_INST = 32'ha;
    localparam logic [31:0] EXC_OVERFLOW     = 32'hc;
    localparam logic [31:0] EXC_TRAP         = 32'hd;
    localparam logic [31:0] EXC_ERET         = 32'he;
    localparam logic [31:0] VEC_INT_OFF      = 32'h20;
    localparam logic [31:0] VEC_GEN_OFF      = 32'h40;
    typedef enum logic {ST_IDLE, ST_FLUSH_HOLD} ctrl_state_e;
endpackage

// File: rtl/pipeline_ctrl_gen_if.sv
// pipeline_ctrl_gen_if: request/redirect bundle between pipeline stages and the stall/flush controller
interface pipeline_ctrl_gen_if #(
    parameter int NUM_STAGES = 6,
    parameter int ADDR_W     = 32,
    parameter int EXC_W      = 32
);
    logic [NUM_STAGES-3:0] stallreq;
    logic [EXC_W-1:0]      exception_i;
    logic [ADDR_W-1:0]     cp0_epc_i;
    logic                  ebase_we;
    logic [ADDR_W-1:0]     ebase_wdata;
    logic [NUM_STAGES-1:0] stall;
    logic                  flush;
    logic [ADDR_W-1:0]     exception_handler_addr;
    logic                  stall_timeout;
    logic [31:0]           stall_cycles;
    modport master (
        output stallreq, exception_i, cp0_epc_i, ebase_we, ebase_wdata,
        input  stall, flush, exception_handler_addr, stall_timeout, stall_cycles
    );
    modport slave (
        input  stallreq, exception_i, cp0_epc_i, ebase_we, ebase_wdata,
        output stall, flush, exception_handler_addr, stall_timeout, stall_cycles
    );
endinterface

// File: rtl/pipeline_ctrl_gen_stall_mask_gen.sv
// stall_mask_gen: highest stage request -> nested thermometer stall mask
module stall_mask_gen #(
    parameter int NUM_STAGES   = 6,
    parameter bit IF_DS_EXTEND = 1'b1
) (
    input  logic [NUM_STAGES-3:0] req,
    output logic [NUM_STAGES-1:0] mask
);
    // request i holds PC and stage registers 1..i+1; an IF request may also hold IF/ID
    always_comb begin
        mask = '0;
        for (int i = 0; i < NUM_STAGES - 2; i++)
            for (int k = 0; k < NUM_STAGES; k++)
                if (req[i] && (k <= i + 1 || (IF_DS_EXTEND && i == 0 && k == 2)))
                    mask[k] = 1'b1;
    end
endmodule

// File: rtl/pipeline_ctrl_gen.sv
// pipeline_ctrl_gen: stall arbitration, exception flush/redirect, EBASE, stall watchdog and counter
module pipeline_ctrl_gen
    import pipeline_ctrl_gen_pkg::*;
#(
    parameter int                NUM_STAGES   = 6,
    parameter int                ADDR_W       = 32,
    parameter int                EXC_W        = 32,
    parameter int                FLUSH_CYCLES = 1,
    parameter bit                IF_DS_EXTEND = 1'b1,
    parameter logic [ADDR_W-1:0] RESET_EBASE  = '0,
    parameter int                WDT_LIMIT    = 1024
) (
    input logic               clk,
    input logic               rst,
    pipeline_ctrl_gen_if.slave bus
);
    localparam int                CW        = FLUSH_CYCLES > 2 ? $clog2(FLUSH_CYCLES) : 1;
    localparam int                WW        = $clog2(WDT_LIMIT + 2);
    localparam logic [CW-1:0]     HOLD_LOAD = CW'(FLUSH_CYCLES > 1 ? FLUSH_CYCLES - 2 : 0);
    localparam logic [WW-1:0]     WLIM      = WW'(WDT_LIMIT);
    localparam logic [ADDR_W-1:0] PAGE_MASK = ~ADDR_W'(32'hfff);
    ctrl_state_e           state;
    logic [CW-1:0]         hold_cnt;
    logic [ADDR_W-1:0]     hold_addr, ebase, vec_addr;
    logic [NUM_STAGES-1:0] mask;
    logic [WW-1:0]         wdt;
    logic                  timeout, exc, in_hold;
    logic [31:0]           cycles;
    stall_mask_gen #(.NUM_STAGES(NUM_STAGES), .IF_DS_EXTEND(IF_DS_EXTEND)) u_mask (
        .req  (bus.stallreq),
        .mask (mask)
    );
    assign in_hold  = state == ST_FLUSH_HOLD;
    assign exc      = rst && !in_hold && bus.exception_i != '0;
    assign vec_addr = bus.exception_i == EXC_W'(EXC_ERET) ? bus.cp0_epc_i :
                      ebase + ADDR_W'(bus.exception_i == EXC_W'(EXC_INTERRUPT) ? VEC_INT_OFF : VEC_GEN_OFF);
    assign bus.flush                  = exc || in_hold;
    assign bus.exception_handler_addr = in_hold ? hold_addr : exc ? vec_addr : '0;
    assign bus.stall                  = (rst && !bus.flush) ? mask : '0;
    assign bus.stall_timeout          = timeout;
    assign bus.stall_cycles           = cycles;
    // flush sequencer: first flush cycle is combinational, the remaining ones replay the latched target
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            hold_cnt  <= '0;
            hold_addr <= '0;
        end else if (in_hold) begin
            state    <= hold_cnt == '0 ? ST_IDLE : ST_FLUSH_HOLD;
            hold_cnt <= hold_cnt - CW'(hold_cnt != '0);
        end else if (exc) begin
            state     <= FLUSH_CYCLES > 1 ? ST_FLUSH_HOLD : ST_IDLE;
            hold_cnt  <= HOLD_LOAD;
            hold_addr <= vec_addr;
        end
    end
    // EBASE is page aligned; a write lands after any same-cycle exception has used the old value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ebase <= RESET_EBASE & PAGE_MASK;
        else if (bus.ebase_we) ebase <= bus.ebase_wdata & PAGE_MASK;
    end
    // watchdog: run length of consecutive stalled cycles, saturating, with a sticky timeout flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdt     <= '0;
            timeout <= 1'b0;
        end else if (bus.stall == '0) begin
            wdt <= '0;
        end else begin
            wdt <= wdt == WLIM ? wdt : wdt + WW'(1);
            if (WDT_LIMIT != 0 && wdt == WLIM - WW'(1)) timeout <= 1'b1;
        end
    end
    // free-running count of cycles the PC was held
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cycles <= '0;
        else cycles <= cycles + 32'(bus.stall[0]);
    end
endmodule

// File: tb/tb_pipeline_ctrl_gen.sv
// tb_pipeline_ctrl_gen: scoreboard bench driving two differently parametrised controllers
module tb_pipeline_ctrl_gen;
    typedef struct packed {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] addr;
        logic        to;
        logic [31:0] cyc;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];
    int          m_left[2];
    int          m_wdt[2];
    bit          m_to[2];
    logic [31:0] m_hold[2];
    logic [31:0] m_ebase[2];
    logic [31:0] m_cyc[2];
    always #5 clk = ~clk;
    pipeline_ctrl_gen_if #(.NUM_STAGES(6), .ADDR_W(32), .EXC_W(32)) ia ();
    pipeline_ctrl_gen_if #(.NUM_STAGES(6), .ADDR_W(32), .EXC_W(32)) ib ();
    pipeline_ctrl_gen #(.WDT_LIMIT(4)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    pipeline_ctrl_gen #(.FLUSH_CYCLES(3), .IF_DS_EXTEND(1'b0), .RESET_EBASE(32'hBFC0_1ABC), .WDT_LIMIT(0))
        dut_b (.clk(clk), .rst(rst), .bus(ib));
    function automatic int fc(int d);
        return d == 1 ? 3 : 1;
    endfunction
    function automatic int lim(int d);
        return d == 1 ? 0 : 4;
    endfunction
    function automatic logic [5:0] thermo(logic [3:0] req, bit ext);
        int h;
        h = -1;
        for (int i = 0; i < 4; i++) if (req[i]) h = i;
        if (h < 0) return 6'd0;
        return 6'((1 << ((h == 0 && ext) ? 3 : h + 2)) - 1);
    endfunction
    task automatic model(int d, logic r, logic [3:0] req, logic [31:0] exc, logic [31:0] epc, logic we, logic [31:0] wd);
        exp_t e;
        e = '0;
        if (!r) begin
            m_left[d]  = 0;
            m_wdt[d]   = 0;
            m_to[d]    = 0;
            m_hold[d]  = 0;
            m_cyc[d]   = 0;
            m_ebase[d] = (d == 1 ? 32'hBFC0_1ABC : 32'h0) & ~32'hfff;
        end else begin
            e.to  = m_to[d];
            e.cyc = m_cyc[d];
            if (m_left[d] > 0) begin
                e.flush = 1;
                e.addr  = m_hold[d];
                m_left[d]--;
            end else if (exc != 0) begin
                e.flush = 1;
                e.addr  = exc == 32'he ? epc : m_ebase[d] + (exc == 32'h1 ? 32'h20 : 32'h40);
                if (fc(d) > 1) begin
                    m_left[d] = fc(d) - 1;
                    m_hold[d] = e.addr;
                end
            end else begin
                e.stall = thermo(req, d == 0);
            end
            if (e.stall == 0) m_wdt[d] = 0;
            else begin
                m_wdt[d] = m_wdt[d] + 1 > lim(d) ? lim(d) : m_wdt[d] + 1;
                if (lim(d) != 0 && m_wdt[d] >= lim(d)) m_to[d] = 1;
            end
            m_cyc[d] = m_cyc[d] + 32'(e.stall[0]);
            if (we) m_ebase[d] = wd & ~32'hfff;
        end
        if (d == 0) qa.push_back(e);
        else qb.push_back(e);
    endtask
    task automatic tick(logic r, logic [3:0] req, logic [31:0] exc, logic [31:0] epc, logic we, logic [31:0] wd);
        @(posedge clk);
        #1;
        rst = r;
        ia.stallreq = req;  ib.stallreq = req;
        ia.exception_i = exc;  ib.exception_i = exc;
        ia.cp0_epc_i = epc;  ib.cp0_epc_i = epc;
        ia.ebase_we = we;  ib.ebase_we = we;
        ia.ebase_wdata = wd;  ib.ebase_wdata = wd;
        model(0, r, req, exc, epc, we, wd);
        model(1, r, req, exc, epc, we, wd);
    endtask
    task automatic st(logic [3:0] req);
        tick(1'b1, req, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask
    task automatic ex(logic [3:0] req, logic [31:0] exc, logic [31:0] epc);
        tick(1'b1, req, exc, epc, 1'b0, 32'h0);
    endtask
    task automatic rs();
        tick(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask
    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, want);
        end
    endtask
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("a.stall", 32'(ia.stall), 32'(e.stall));
                chk("a.flush", 32'(ia.flush), 32'(e.flush));
                chk("a.addr", ia.exception_handler_addr, e.addr);
                chk("a.timeout", 32'(ia.stall_timeout), 32'(e.to));
                chk("a.cycles", ia.stall_cycles, e.cyc);
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("b.stall", 32'(ib.stall), 32'(e.stall));
                chk("b.flush", 32'(ib.flush), 32'(e.flush));
                chk("b.addr", ib.exception_handler_addr, e.addr);
                chk("b.timeout", 32'(ib.stall_timeout), 32'(e.to));
                chk("b.cycles", ib.stall_cycles, e.cyc);
            end
        end
    end
    initial begin
        int r;
        logic [31:0] exc;
        ia.stallreq = '0;  ib.stallreq = '0;
        ia.exception_i = '0;  ib.exception_i = '0;
        ia.cp0_epc_i = '0;  ib.cp0_epc_i = '0;
        ia.ebase_we = 1'b0;  ib.ebase_we = 1'b0;
        ia.ebase_wdata = '0;  ib.ebase_wdata = '0;
        repeat (3) rs();
        st(4'b0100); st(4'b0110); st(4'b1000); st(4'b0001); st(4'b0000);
        ex(4'b1111, 32'h1, 32'h0); st(4'b0000); st(4'b0000);
        ex(4'b1111, 32'h8, 32'h0); st(4'b0000); st(4'b0000);
        ex(4'b0000, 32'h55, 32'h0); st(4'b0000); st(4'b0000);
        tick(1'b1, 4'b0000, 32'hc, 32'h0, 1'b1, 32'h8000_1234); st(4'b0000); st(4'b0000);
        ex(4'b0000, 32'hc, 32'h0); st(4'b0000); st(4'b0000);
        ex(4'b0010, 32'he, 32'hBFC0_0100); ex(4'b0010, 32'h0, 32'h0); ex(4'b0010, 32'h1, 32'h0);
        st(4'b0010); st(4'b0010); st(4'b0000); st(4'b0000);
        repeat (2) rs();
        repeat (3) st(4'b0001);
        st(4'b0000);
        repeat (3) st(4'b0100);
        st(4'b0000);
        repeat (5) st(4'b1000);
        repeat (3) st(4'b0000);
        ex(4'b0000, 32'h8, 32'h0);
        tick(1'b0, 4'b0100, 32'h0, 32'h0, 1'b0, 32'h0);
        rs();
        st(4'b0100); st(4'b0001); st(4'b0000);
        repeat (400) begin
            r = $urandom_range(0, 15);
            exc = r < 10 ? 32'h0 : r == 10 ? 32'h1 : r == 11 ? 32'he : r == 12 ? 32'h8 :
                  r == 13 ? 32'hd : ($urandom() | 32'h1);
            tick(1'($urandom_range(0, 63) != 0), 4'($urandom()), exc, $urandom(),
                 1'($urandom_range(0, 15) == 0), $urandom());
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("queue.drained", 32'(qa.size() + qb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl_gen.md
Name: pipeline_ctrl_gen

Overview:
Parametrised successor to the pipeline stall/flush controller for the MIPS-style core. It arbitrates per-stage stall requests into a nested stall vector and converts the MEM-stage exception code into a flush and a handler address. Flush can be held for N cycles, and the exception base is a programmable register. A stall watchdog and a stall-cycle counter are included. It sits beside pc_reg and the stage registers, and drives their stall and flush inputs.

Parameters:
NUM_STAGES, 6, stall vector width (bit0 = PC, bit k = k-th stage register); NUM_REQ = NUM_STAGES-2 (derived).
ADDR_W, 32, width of handler address, EPC and EBASE.
EXC_W, 32, exception code width.
FLUSH_CYCLES, 1, cycles flush is asserted per exception (>=1).
IF_DS_EXTEND, 1, when 1 an IF request also stalls the IF/ID register (delay-slot protection).
RESET_EBASE, 0, EBASE reset value.
WDT_LIMIT, 1024, consecutive stalled cycles before timeout (0 disables).

Ports:
clk  in  1  clock.
rst  in  1  asynchronous, active-low reset (asserted when 0).
stallreq  in  NUM_REQ  bit i = stall request from stage i (0 = IF, 1 = ID, 2 = EX, 3 = MEM for default).
exception_i  in  EXC_W  exception code from MEM; 0 = none.
cp0_epc_i  in  ADDR_W  EPC for eret.
ebase_we  in  1  EBASE write enable.
ebase_wdata  in  ADDR_W  EBASE write data.
stall  out  NUM_STAGES  per-stage hold.
flush  out  1  clear all stage registers.
exception_handler_addr  out  ADDR_W  redirect target, valid while flush=1.
stall_timeout  out  1  sticky watchdog flag.
stall_cycles  out  32  count of cycles with stall[0]=1.

Behaviour:
- Reset (rst=0, async): state IDLE, all outputs 0, EBASE=RESET_EBASE with bits [11:0] forced 0, counters 0.
- States: IDLE, FLUSH_HOLD. A hold counter holds FLUSH_CYCLES-1 down to 0.
- IDLE, exception_i != 0:
  - flush=1 in the same cycle (combinational); stall=0.
  - Latch the address. If FLUSH_CYCLES>1, go to FLUSH_HOLD.
- Address decode: 32'h1 interrupt -> EBASE+0x20. 32'h8, 32'ha, 32'hc, 32'hd -> EBASE+0x40. 32'he eret -> cp0_epc_i. Any other nonzero code -> EBASE+0x40.
- FLUSH_HOLD:
  - flush=1, stall=0, address = latched value.
  - exception_i and stallreq are ignored.
  - Leave to IDLE when the counter reaches 0. Total flush width is exactly FLUSH_CYCLES.
- IDLE, no exception:
  - flush=0, address=0.
  - Let h = highest asserted stallreq index. stall bits [h+1:0] = 1, rest 0.
  - If h=0 and IF_DS_EXTEND=1, stall bits [2:0] = 1.
  - No request -> stall=0. Because masks nest, the highest request wins.
- Exception has priority over all stall requests in the same cycle.
- EBASE write: takes effect the next cycle, low 12 bits forced 0. An exception in the same cycle uses the old EBASE.
- Watchdog:
  - wdt counter increments each cycle stall!=0, and clears on stall==0 or flush.
  - It saturates at WDT_LIMIT. Reaching WDT_LIMIT sets stall_timeout, which is cleared only by reset.
  - WDT_LIMIT=0 disables the watchdog, so stall_timeout stays 0.
- stall_cycles: +1 each cycle stall[0]=1; wraps 2^32-1 -> 0.
- Address arithmetic is modulo 2^ADDR_W.

Decomposition:
- Shared package/defines holds:
  - the exception code constants (EXC_INTERRUPT=1, SYSCALL=8, INVALID_INST=0xa, OVERFLOW=0xc, TRAP=0xd, ERET=0xe);
  - vector offsets 0x20 and 0x40;
  - state encodings.
- One natural sub-module: stall_mask_gen (combinational priority-to-thermometer, parametrised by NUM_STAGES/IF_DS_EXTEND).

Test Plan:
1. Defaults, stallreq=4'b0100 (EX) and 4'b0110 -> stall=6'b001111 both. 4'b1000 -> 6'b011111. 4'b0001 -> 6'b000111; with IF_DS_EXTEND=0 -> 6'b000011.
2. exception_i=32'h1 with stallreq=4'b1111, EBASE=0 -> same cycle flush=1, stall=0, addr=0x20. 32'h8 -> 0x40. 32'h55 -> 0x40.
3. Write EBASE=0x8000_1234, then exception 32'hc in the write cycle -> addr 0x40. Next exception 32'hc -> addr 0x8000_1040.
4. FLUSH_CYCLES=3, exception 32'he with epc=0xBFC0_0100, exception_i cleared next cycle and a new 32'h1 injected in cycle 2 -> flush high exactly 3 cycles, addr stays 0xBFC0_0100 throughout, then stall follows stallreq.
5. WDT_LIMIT=4, stallreq held 5 cycles -> stall_timeout rises after the 4th stalled cycle and stays 1 after stallreq drops. Stalling 3 cycles, 1 idle, 3 stalled -> no timeout. stall_cycles counts 6.
6. Assert rst low mid FLUSH_HOLD (asynchronously, between edges) -> all outputs 0 immediately, EBASE=RESET_EBASE. Normal arbitration resumes after release.
